fifo_wptr_full: RTL and testbench
=================================

// Module: fifo_wptr_full
// PURPOSE
//  Write-side control for the async FIFO: owns write pointer, memory write strobe and full flag.
//  Sits directly upstream of the FIFO memory: drives its waddr, wclk_en and wfull.
//  Brings the read-domain Gray pointer into wclk through a 2-flop synchroniser.
//  Exports its own Gray write pointer to the read-side control.
// PARAMETERS
//  ADDR_SIZE    4  memory address width; DEPTH = 1<<ADDR_SIZE; legal range ADDR_SIZE>=2
//  AFULL_MARGIN 2  free-slot count at/below which walmost_full asserts (FIFO_WLEVEL_EN only)
// PORTS
//  wclk         in   1            write clock; all state on rising edge
//  wrst         in   1            synchronous, active-high reset
//  winc         in   1            write request from producer
//  rptr         in   ADDR_SIZE+1  read pointer, Gray, rclk domain (asynchronous to wclk)
//  waddr        out  ADDR_SIZE    memory write address
//  wclk_en      out  1            memory write enable = winc & ~wfull (combinational)
//  wfull        out  1            FIFO full, registered
//  wptr         out  ADDR_SIZE+1  write pointer, Gray, registered; goes to the read domain
//  wlevel       out  ADDR_SIZE+1  occupancy seen from write side (FIFO_WLEVEL_EN only)
//  walmost_full out  1            almost-full, registered (FIFO_WLEVEL_EN only)
// BEHAVIOUR
//  Clock and reset: one clock (wclk); reset is synchronous and active-high (wrst).
//  Reset: wbin=0, wptr=0, wfull=0, sync flops rq1/rq2=0, wlevel=0, walmost_full=0.
//   Reset wins over winc on the same edge. Mid-operation reset discards FIFO contents.
//  Accept: write accepted on an edge iff winc & ~wfull. wbin_next = wbin + accept.
//   Wraps modulo 2^(ADDR_SIZE+1).
//  wptr_next = (wbin_next>>1) ^ wbin_next. Exactly one bit changes per accepted write.
//  waddr = wbin[ADDR_SIZE-1:0]. Zero-latency: the address is valid in the same cycle
//   as wclk_en, and memory captures at that edge.
//  Sync: rq1<=rptr; rq2<=rq1. rptr reaches rq2 two wclk edges after it changes.
//  Full: wfull <= (wptr_next == {~rq2[A:A-1], rq2[A-2:0]}), with A=ADDR_SIZE.
//   Asserts on the same edge that accepts the write filling the last slot.
//  Write while full: ignored. wbin, wptr and waddr hold; wclk_en=0; no error flag.
//  Deassert: pessimistic. wfull clears on the 3rd wclk edge after rptr advances:
//   2 sync edges plus 1 register edge.
//  Simultaneous read and write at full: the write is refused that cycle.
//   It succeeds once the synced rptr shows free space.
//  Never overflows; may under-report free space (safe).
// CONFIGURATION
//  Macro FIFO_WLEVEL_EN.
//  Defined:
//   - rbin_s = gray2bin(rq2).
//   - wlevel <= wbin_next - rbin_s (ADDR_SIZE+1 bits, modulo).
//   - walmost_full <= (DEPTH - wlevel_next) <= AFULL_MARGIN.
//   - Both outputs are registered alongside wfull.
//  Undefined:
//   - wlevel and walmost_full ports are absent.
//   - No Gray-to-binary logic is present.
//   - wfull behaviour is identical in both builds.
// STRUCTURE
//  Package fifo_pkg holds:
//   - localparam DEPTH = 1<<ADDR_SIZE
//   - functions bin2gray and gray2bin (parameterised width)
//   - a shared full/empty compare helper
//  Sub-module fifo_sync_2ff #(WIDTH): 2-flop synchroniser with synchronous reset.
//   Instanced once for rptr. The read side reuses it for wptr.
// TESTING (ADDR_SIZE=4, DEPTH=16)
//  1 Reset: wrst=1 for 2 edges with winc=1, rptr=0
//    -> waddr=0, wptr=5'b00000, wfull=0, wclk_en=0 after release.
//  2 Fill: rptr=0, winc=1 for 16 edges
//    -> waddr steps 0..15, then 0.
//    -> wfull=1 on the 16th edge; wptr=5'b11000.
//  3 Over-write: from full, winc=1 for 4 edges
//    -> wclk_en=0, wptr stays 5'b11000, waddr stays 0.
//  4 Drain release: from full, set rptr=5'b00001
//    -> wfull=1 for 2 edges, 0 on the 3rd edge.
//    -> next winc accepted at waddr=0.
//  5 Wrap: 40 writes with rptr tracking wptr 4 behind
//    -> wfull never asserts.
//    -> waddr wraps 15->0 twice; each wptr change has Hamming distance 1.
//  6 Mid reset: assert wrst with 7 writes done and winc=1
//    -> next edge wptr=0, waddr=0, wfull=0; no write accepted that edge.
//  (FIFO_WLEVEL_EN) after 14 writes with rptr=0
//    -> wlevel=14, walmost_full=1; at 13 writes -> walmost_full=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the async FIFO: Gray/binary conversion and the
// full/empty pointer compare used by both the write-side and read-side controls.
package fifo_pkg;

    localparam int unsigned ADDR_SIZE_DFLT = 4;
    localparam int unsigned DEPTH          = 1 << ADDR_SIZE_DFLT;

    // Functions work on a zero-extended 32-bit value, which makes them width-agnostic.
    localparam int unsigned PtrMaxW = 32;

    function automatic logic [PtrMaxW-1:0] bin2gray(input logic [PtrMaxW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PtrMaxW-1:0] gray2bin(input logic [PtrMaxW-1:0] g);
        logic [PtrMaxW-1:0] b;
        b = '0;
        for (int i = 0; i < PtrMaxW; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    // Mask of the two pointer MSBs; full is "same pointer with both MSBs inverted".
    function automatic logic [PtrMaxW-1:0] full_mask(input int unsigned addr_size);
        return PtrMaxW'(3) << (addr_size - 1);
    endfunction

    // Full compare uses full_mask(); empty compare on the read side passes a zero mask.
    function automatic logic ptr_cmp(input logic [PtrMaxW-1:0] a,
                                     input logic [PtrMaxW-1:0] b,
                                     input logic [PtrMaxW-1:0] mask);
        return a == (b ^ mask);
    endfunction

endpackage

// File: rtl/fifo_sync_2ff.sv
// Two-flop synchroniser with synchronous active-high reset, for Gray pointers
// crossing between the FIFO clock domains.
module fifo_sync_2ff #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/fifo_wptr_full.sv
// Async FIFO write-side control: write pointer, memory write strobe and full flag.
// Optional occupancy/almost-full outputs are built when FIFO_WLEVEL_EN is defined.
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = 4
`ifdef FIFO_WLEVEL_EN
    ,
    parameter int unsigned AFULL_MARGIN = 2
`endif
) (
    input  logic                 wclk,
    input  logic                 wrst,
    input  logic                 winc,
    input  logic [ADDR_SIZE:0]   rptr,
    output logic [ADDR_SIZE-1:0] waddr,
    output logic                 wclk_en,
    output logic                 wfull,
    output logic [ADDR_SIZE:0]   wptr
`ifdef FIFO_WLEVEL_EN
    ,
    output logic [ADDR_SIZE:0]   wlevel,
    output logic                 walmost_full
`endif
);

    localparam int unsigned PtrW = ADDR_SIZE + 1;

    logic [PtrW-1:0] wbin_q, wbin_d;
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic            wfull_q, wfull_d;
    logic [PtrW-1:0] rq2;

    fifo_sync_2ff #(
        .WIDTH(PtrW)
    ) u_rptr_sync (
        .clk(wclk),
        .rst(wrst),
        .d  (rptr),
        .q  (rq2)
    );

    always_comb begin
        wclk_en = winc & ~wfull_q;
        wbin_d  = wbin_q + {{ADDR_SIZE{1'b0}}, wclk_en};
        wptr_d  = PtrW'(bin2gray(PtrMaxW'(wbin_d)));
        // Compare against the next pointer so full asserts on the filling write's edge.
        wfull_d = ptr_cmp(PtrMaxW'(wptr_d), PtrMaxW'(rq2), full_mask(ADDR_SIZE));
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_q  <= '0;
            wptr_q  <= '0;
            wfull_q <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wptr_q  <= wptr_d;
            wfull_q <= wfull_d;
        end
    end

    assign waddr = wbin_q[ADDR_SIZE-1:0];
    assign wfull = wfull_q;
    assign wptr  = wptr_q;

`ifdef FIFO_WLEVEL_EN
    localparam int unsigned Depth = 1 << ADDR_SIZE;

    logic [PtrW-1:0] rbin_s;
    logic [PtrW-1:0] wlevel_q, wlevel_d;
    logic            walmost_q, walmost_d;

    always_comb begin
        rbin_s    = PtrW'(gray2bin(PtrMaxW'(rq2)));
        wlevel_d  = wbin_d - rbin_s;
        walmost_d = (Depth - 32'(wlevel_d)) <= AFULL_MARGIN;
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wlevel_q  <= '0;
            walmost_q <= 1'b0;
        end else begin
            wlevel_q  <= wlevel_d;
            walmost_q <= walmost_d;
        end
    end

    assign wlevel       = wlevel_q;
    assign walmost_full = walmost_q;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed self-checking bench for fifo_wptr_full at ADDR_SIZE=4 (DEPTH=16).
// Level/almost-full checks are included when FIFO_WLEVEL_EN is defined.
module tb_fifo_wptr_full;

    logic       wclk = 1'b0;
    logic       wrst = 1'b1;
    logic       winc = 1'b0;
    logic [4:0] rptr = 5'd0;
    logic [3:0] waddr;
    logic       wclk_en;
    logic       wfull;
    logic [4:0] wptr;
`ifdef FIFO_WLEVEL_EN
    logic [4:0] wlevel;
    logic       walmost_full;
`endif

    int total = 0;
    int bad   = 0;

    always #5 wclk = ~wclk;

    fifo_wptr_full #(
        .ADDR_SIZE(4)
`ifdef FIFO_WLEVEL_EN
        ,
        .AFULL_MARGIN(2)
`endif
    ) dut (
        .wclk        (wclk),
        .wrst        (wrst),
        .winc        (winc),
        .rptr        (rptr),
        .waddr       (waddr),
        .wclk_en     (wclk_en),
        .wfull       (wfull),
        .wptr        (wptr)
`ifdef FIFO_WLEVEL_EN
        ,
        .wlevel      (wlevel),
        .walmost_full(walmost_full)
`endif
    );

    function automatic logic [4:0] gray5(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        wrst = 1'b1;
        winc = 1'b0;
        rptr = 5'd0;
        tick();
        tick();
        wrst = 1'b0;
    endtask

    task automatic test_reset();
        wrst = 1'b1;
        winc = 1'b1;
        rptr = 5'd0;
        tick();
        tick();
        total++; if (wptr !== 5'b00000) begin bad++; $display("FAIL reset_wptr: got %b want 00000", wptr); end
        total++; if (waddr !== 4'd0) begin bad++; $display("FAIL reset_waddr: got %0d want 0", waddr); end
        total++; if (wfull !== 1'b0) begin bad++; $display("FAIL reset_wfull: got %b want 0", wfull); end
        wrst = 1'b0;
        winc = 1'b0;
        #1;
        total++; if (wclk_en !== 1'b0) begin bad++; $display("FAIL reset_wclk_en: got %b want 0", wclk_en); end
    endtask

    task automatic test_fill();
        rptr = 5'd0;
        winc = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            total++; if (waddr !== 4'(i)) begin bad++; $display("FAIL fill_waddr[%0d]: got %0d want %0d", i, waddr, i); end
            total++; if (wclk_en !== 1'b1) begin bad++; $display("FAIL fill_wclk_en[%0d]: got %b want 1", i, wclk_en); end
            tick();
            if (i == 14) begin
                total++; if (wfull !== 1'b0) begin bad++; $display("FAIL fill_not_full_15: got %b want 0", wfull); end
            end
        end
        total++; if (wfull !== 1'b1) begin bad++; $display("FAIL fill_wfull: got %b want 1", wfull); end
        total++; if (wptr !== 5'b11000) begin bad++; $display("FAIL fill_wptr: got %b want 11000", wptr); end
        total++; if (waddr !== 4'd0) begin bad++; $display("FAIL fill_waddr_wrap: got %0d want 0", waddr); end
    endtask

    task automatic test_overwrite();
        winc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (wclk_en !== 1'b0) begin bad++; $display("FAIL ovw_wclk_en[%0d]: got %b want 0", i, wclk_en); end
            tick();
            total++; if (wptr !== 5'b11000) begin bad++; $display("FAIL ovw_wptr[%0d]: got %b want 11000", i, wptr); end
            total++; if (waddr !== 4'd0) begin bad++; $display("FAIL ovw_waddr[%0d]: got %0d want 0", i, waddr); end
            total++; if (wfull !== 1'b1) begin bad++; $display("FAIL ovw_wfull[%0d]: got %b want 1", i, wfull); end
        end
    endtask

    task automatic test_drain_release();
        winc = 1'b0;
        rptr = 5'b00001;
        tick();
        total++; if (wfull !== 1'b1) begin bad++; $display("FAIL drain_edge1: got %b want 1", wfull); end
        tick();
        total++; if (wfull !== 1'b1) begin bad++; $display("FAIL drain_edge2: got %b want 1", wfull); end
        tick();
        total++; if (wfull !== 1'b0) begin bad++; $display("FAIL drain_edge3: got %b want 0", wfull); end
        winc = 1'b1;
        #1;
        total++; if (wclk_en !== 1'b1) begin bad++; $display("FAIL drain_accept_en: got %b want 1", wclk_en); end
        total++; if (waddr !== 4'd0) begin bad++; $display("FAIL drain_accept_addr: got %0d want 0", waddr); end
        tick();
        winc = 1'b0;
        total++; if (wptr !== 5'b11001) begin bad++; $display("FAIL drain_wptr: got %b want 11001", wptr); end
        total++; if (wfull !== 1'b1) begin bad++; $display("FAIL drain_refull: got %b want 1", wfull); end
    endtask

    task automatic test_wrap();
        logic [4:0] n;
        logic [4:0] prev_ptr;
        logic [3:0] prev_addr;
        int         wraps;
        do_reset();
        n         = 5'd0;
        prev_ptr  = 5'd0;
        prev_addr = 4'd0;
        wraps     = 0;
        winc      = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rptr = (i >= 4) ? gray5(n - 5'd4) : 5'd0;
            #1;
            total++; if (waddr !== n[3:0]) begin bad++; $display("FAIL wrap_waddr[%0d]: got %0d want %0d", i, waddr, n[3:0]); end
            total++; if (wfull !== 1'b0) begin bad++; $display("FAIL wrap_wfull[%0d]: got %b want 0", i, wfull); end
            tick();
            n = n + 5'd1;
            total++; if (wptr !== gray5(n)) begin bad++; $display("FAIL wrap_wptr[%0d]: got %b want %b", i, wptr, gray5(n)); end
            total++; if ($countones(wptr ^ prev_ptr) != 1) begin bad++; $display("FAIL wrap_hamming[%0d]: got %0d want 1", i, $countones(wptr ^ prev_ptr)); end
            if (prev_addr == 4'd15 && waddr == 4'd0) wraps++;
            prev_ptr  = wptr;
            prev_addr = waddr;
        end
        winc = 1'b0;
        total++; if (wraps != 2) begin bad++; $display("FAIL wrap_count: got %0d want 2", wraps); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        winc = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        total++; if (waddr !== 4'd7) begin bad++; $display("FAIL midrst_pre_addr: got %0d want 7", waddr); end
        wrst = 1'b1;
        tick();
        total++; if (wptr !== 5'd0) begin bad++; $display("FAIL midrst_wptr: got %b want 00000", wptr); end
        total++; if (waddr !== 4'd0) begin bad++; $display("FAIL midrst_waddr: got %0d want 0", waddr); end
        total++; if (wfull !== 1'b0) begin bad++; $display("FAIL midrst_wfull: got %b want 0", wfull); end
        wrst = 1'b0;
        tick();
        winc = 1'b0;
        total++; if (wptr !== 5'b00001) begin bad++; $display("FAIL midrst_resume_wptr: got %b want 00001", wptr); end
        total++; if (waddr !== 4'd1) begin bad++; $display("FAIL midrst_resume_addr: got %0d want 1", waddr); end
    endtask

`ifdef FIFO_WLEVEL_EN
    task automatic test_level();
        do_reset();
        winc = 1'b1;
        for (int i = 0; i < 13; i++) tick();
        total++; if (wlevel !== 5'd13) begin bad++; $display("FAIL level13: got %0d want 13", wlevel); end
        total++; if (walmost_full !== 1'b0) begin bad++; $display("FAIL afull13: got %b want 0", walmost_full); end
        tick();
        winc = 1'b0;
        total++; if (wlevel !== 5'd14) begin bad++; $display("FAIL level14: got %0d want 14", wlevel); end
        total++; if (walmost_full !== 1'b1) begin bad++; $display("FAIL afull14: got %b want 1", walmost_full); end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_overwrite();
        test_drain_release();
        test_wrap();
        test_mid_reset();
`ifdef FIFO_WLEVEL_EN
        test_level();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
